tc_bit_writer: RTL and testbench

Sequential writer that stores a parallel word into a bank of 1-bit storage cells, one bit per clock. It drives the cells' save/data/address inputs and pulses `done` when finished. It sits between a word-level producer (register, decoder, or control FSM) and a column of single-bit memory cells. An optional readback pass checks the stored bits against the original word.

---
 rtl/tc_bit_pkg.sv | 16 +
 rtl/tc_bit_writer_if.sv | 26 ++
 rtl/tc_bit_writer.sv | 134 +++++++++++++
 tb/tb_tc_bit_writer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/tc_bit_pkg.sv
// Shared types and helpers for the tc_bit_writer serial bit-cell writer.
package tc_bit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } tc_bit_writer_state_t;

  // Index counter width: one bit wider than the address so it can hold WIDTH itself.
  function automatic int tc_bit_idx_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/tc_bit_writer_if.sv
// Producer/cell-bank bundle for tc_bit_writer; master is the writer, slave the environment.
interface tc_bit_writer_if #(
  parameter int WIDTH = 8
);
  localparam int ADDR_W = $clog2(WIDTH);

  logic              start;
  logic [WIDTH-1:0]  word;
  logic              busy;
  logic              done;
  logic              save;
  logic              bit_out;
  logic [ADDR_W-1:0] bit_addr;
  logic              rd_bit;
  logic              error;

  modport master (
    input  start, word, rd_bit,
    output busy, done, save, bit_out, bit_addr, error
  );

  modport slave (
    output start, word, rd_bit,
    input  busy, done, save, bit_out, bit_addr, error
  );
endinterface

// File: rtl/tc_bit_writer.sv
// Writes a parallel word into WIDTH single-bit cells, LSB first, one bit per clock.
// Define TC_BIT_WRITER_VERIFY_EN to build the readback pass and sticky error flag.
module tc_bit_writer
  import tc_bit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  tc_bit_writer_if.master bus
);

  localparam int ADDR_W = $clog2(WIDTH);
  localparam int IDX_W  = tc_bit_idx_w(WIDTH);

  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_WRITE  = 2'(WRITE);
  localparam logic [1:0] ST_DONE   = 2'(DONE);
`ifdef TC_BIT_WRITER_VERIFY_EN
  localparam logic [1:0] ST_VERIFY = 2'(VERIFY);
  localparam logic [IDX_W-1:0] WIDTH_IDX = IDX_W'(WIDTH);
`endif
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [WIDTH-1:0]  r_shift;
  logic              r_busy;
  logic              r_done;
  logic              r_save;
  logic              r_bit_out;
  logic [ADDR_W-1:0] r_bit_addr;
  logic              r_error;

  logic [IDX_W-1:0]  w_idx_next;
  logic [WIDTH-1:0]  w_rot;

  assign w_idx_next = r_idx + 1'b1;
  // Rotating rather than shifting leaves the word intact after WIDTH steps for readback.
  assign w_rot      = {r_shift[0], r_shift[WIDTH-1:1]};

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_shift    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_save     <= 1'b0;
      r_bit_out  <= 1'b0;
      r_bit_addr <= '0;
      r_error    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state    <= ST_WRITE;
            r_shift    <= bus.word;
            r_idx      <= '0;
            r_busy     <= 1'b1;
            r_save     <= 1'b1;
            r_bit_addr <= '0;
            r_bit_out  <= bus.word[0];
            r_error    <= 1'b0;
          end
        end

        ST_WRITE: begin
          r_shift <= w_rot;
          if (r_idx == LAST_IDX) begin
            r_idx      <= '0;
            r_save     <= 1'b0;
            r_bit_addr <= '0;
            r_bit_out  <= 1'b0;
`ifdef TC_BIT_WRITER_VERIFY_EN
            r_state    <= ST_VERIFY;
`else
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
`endif
          end else begin
            r_idx      <= w_idx_next;
            r_bit_addr <= w_idx_next[ADDR_W-1:0];
            r_bit_out  <= w_rot[0];
          end
        end

`ifdef TC_BIT_WRITER_VERIFY_EN
        ST_VERIFY: begin
          // rd_bit lags the address by one cycle, so cycle v checks bit v-1.
          if (r_idx != '0) begin
            r_error <= r_error | (bus.rd_bit != r_shift[0]);
            r_shift <= w_rot;
          end
          if (r_idx == WIDTH_IDX) begin
            r_state    <= ST_DONE;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_bit_addr <= '0;
          end else begin
            r_idx      <= w_idx_next;
            r_bit_addr <= (w_idx_next == WIDTH_IDX) ? '0 : w_idx_next[ADDR_W-1:0];
          end
        end
`endif

        ST_DONE: r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.save     = r_save;
  assign bus.bit_out  = r_bit_out;
  assign bus.bit_addr = r_bit_addr;

`ifdef TC_BIT_WRITER_VERIFY_EN
  assign bus.error = r_error;
`else
  logic w_unused_rd_bit;
  logic w_unused_error;
  assign w_unused_rd_bit = bus.rd_bit;
  assign w_unused_error  = r_error;
  assign bus.error       = 1'b0;
`endif

endmodule

// File: tb/tb_tc_bit_writer.sv
// Directed bench for tc_bit_writer: WIDTH=8 and WIDTH=5 instances over behavioural bit-cell banks.
module tb_tc_bit_writer;

`ifdef TC_BIT_WRITER_VERIFY_EN
  localparam int EXP_LAT8 = 18;
  localparam int EXP_LAT5 = 12;
`else
  localparam int EXP_LAT8 = 9;
  localparam int EXP_LAT5 = 6;
`endif

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  tc_bit_writer_if #(.WIDTH(8)) bus8 ();
  tc_bit_writer_if #(.WIDTH(5)) bus5 ();

  tc_bit_writer #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  tc_bit_writer #(.WIDTH(5)) u_dut5 (.clk(clk), .rst(rst), .bus(bus5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell banks: capture on the falling edge, registered readback on the rising edge.
  logic [7:0] bank8  = 8'h00;
  logic [4:0] bank5  = 5'h00;
  bit         stuck4 = 1'b0;

  always @(negedge clk) begin
    if (bus8.save) bank8[bus8.bit_addr] <= (stuck4 && bus8.bit_addr == 3'd4) ? 1'b0 : bus8.bit_out;
    if (bus5.save) bank5[bus5.bit_addr] <= bus5.bit_out;
  end

  always @(posedge clk) begin
    bus8.rd_bit <= bank8[bus8.bit_addr];
    bus5.rd_bit <= bank5[bus5.bit_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write8(input logic [7:0] w, input bit pulse_ff, input logic exp_err);
    int lat;
    bus8.start = 1'b1;
    bus8.word  = w;
    tick();
    bus8.start = 1'b0;
    bus8.word  = 8'h00;
    check("err_clear", bus8.error, 0);
    for (int k = 0; k < 8; k++) begin
      check("save", bus8.save, 1);
      check("addr", bus8.bit_addr, k);
      check("bit", bus8.bit_out, w[k]);
      check("busy", bus8.busy, 1);
      check("done_early", bus8.done, 0);
      if (pulse_ff) begin
        bus8.start = (k == 2);
        bus8.word  = (k == 2) ? 8'hFF : 8'h00;
      end
      tick();
    end
    bus8.start = 1'b0;
    lat = 9;
    while (!bus8.done && lat < 40) begin
      check("verify_save_off", bus8.save, 0);
      check("verify_busy", bus8.busy, 1);
      tick();
      lat++;
    end
    check("done_lat", lat, EXP_LAT8);
    check("busy_at_done", bus8.busy, 0);
    check("save_at_done", bus8.save, 0);
    check("error_at_done", bus8.error, exp_err);
    tick();
    check("done_pulse", bus8.done, 0);
    repeat (3) begin
      tick();
      check("idle_busy", bus8.busy, 0);
    end
  endtask

  initial begin
    int done_cnt;
    int saves5;
    int done_at;

    rst        = 1'b1;
    bus8.start = 1'b0;
    bus8.word  = 8'h00;
    bus5.start = 1'b0;
    bus5.word  = 5'h00;
    tick();
    tick();

    check("rst_save", bus8.save, 0);
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.done, 0);
    check("rst_error", bus8.error, 0);
    check("rst_addr", bus8.bit_addr, 0);
    check("rst_bit", bus8.bit_out, 0);
    rst = 1'b0;
    tick();

    // 0xA5: bits LSB-first 1,0,1,0,0,1,0,1.
    write8(8'hA5, 1'b0, 1'b0);
    check("bank_a5", bank8, 8'hA5);

    // A start during WRITE is dropped; the bank keeps the first word.
    write8(8'h0F, 1'b1, 1'b0);
    check("bank_ignore_ff", bank8, 8'h0F);

    // Reset during WRITE cycle 3 over a bank holding 0x0F.
    bus8.start = 1'b1;
    bus8.word  = 8'hF0;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_addr", bus8.bit_addr, 3);
    check("pre_rst_save", bus8.save, 1);
    rst = 1'b1;
    #1;
    check("async_save", bus8.save, 0);
    check("async_busy", bus8.busy, 0);
    check("async_addr", bus8.bit_addr, 0);
    check("async_bit", bus8.bit_out, 0);
    tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus8.done) done_cnt++;
      tick();
    end
    check("no_done_after_rst", done_cnt, 0);
    check("bank_partial", bank8, 8'h08);

`ifdef TC_BIT_WRITER_VERIFY_EN
    stuck4 = 1'b1;
    write8(8'h10, 1'b0, 1'b1);
    check("bank_stuck", bank8, 8'h00);
    stuck4 = 1'b0;
    write8(8'h3C, 1'b0, 1'b0);
    check("bank_3c", bank8, 8'h3C);
`else
    write8(8'h3C, 1'b0, 1'b0);
    check("bank_3c", bank8, 8'h3C);
`endif

    // WIDTH=5: index counter must stop at 4.
    bus5.start = 1'b1;
    bus5.word  = 5'h1F;
    tick();
    bus5.start = 1'b0;
    bus5.word  = 5'h00;
    saves5  = 0;
    done_at = -1;
    for (int c = 1; c <= 16; c++) begin
      if (bus5.save) begin
        check("w5_addr", bus5.bit_addr, saves5);
        saves5++;
      end
      if (bus5.done && done_at < 0) done_at = c;
      tick();
    end
    check("w5_saves", saves5, 5);
    check("w5_done_lat", done_at, EXP_LAT5);
    check("w5_bank", bank5, 5'h1F);
    check("w5_busy_idle", bus5.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
